// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: segment patterns
// (a..g, seg[6]=a), invalid-BCD marker and the scan decoder FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        STABLE,
        HELD
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder.
// Ports: seg[6:0] in (a..g), bcd[3:0] out, invalid out (pattern not a digit).
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       invalid
);

    always_comb begin
        bcd     = BCD_INVALID;
        invalid = 1'b0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: debounces each digit
// slot, decodes it to BCD and hands out whole frames via valid/ready.
// Ports: clk, rst_n (sync, active-low), seg[6:0], an[NUM_DIGITS-1:0] in;
// frm_valid, frm_digits[4*N-1:0], frm_err[N-1:0], overrun out;
// frm_ready in.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic                    frm_valid,
    input  logic                    frm_ready,
    output logic [4*NUM_DIGITS-1:0] frm_digits,
    output logic [NUM_DIGITS-1:0]   frm_err,
    output logic                    overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [6:0]              seg_q;
    logic [6:0]              seg_p;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [NUM_DIGITS-1:0]   an_p;
    state_t                  state;
    logic [CW-1:0]           count;
    logic [4*NUM_DIGITS-1:0] stg_digits;
    logic [NUM_DIGITS-1:0]   stg_err;
    logic [NUM_DIGITS-1:0]   seen;
    logic [3:0]              bcd;
    logic                    invalid;
    logic                    changed;
    logic                    one_hot;
    logic                    capture;
    logic                    complete;

    seg7_pattern_decode u_decode (
        .seg     (seg_q),
        .bcd     (bcd),
        .invalid (invalid)
    );

    assign changed  = {seg_q, an_q} != {seg_p, an_p};
    assign one_hot  = $onehot(an_q);
    // count holds how many identical samples were seen so far; this
    // unchanged sample is the last one needed.
    assign capture  = (state == STABLE) && !changed && one_hot &&
                      (count == CW'(STABLE_CYCLES - 1));
    assign complete = &seen;

    // Input registers plus one-cycle-old copy for change detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q <= '0;
            an_q  <= '0;
            seg_p <= '0;
            an_p  <= '0;
        end else begin
            seg_q <= seg;
            an_q  <= an;
            seg_p <= seg_q;
            an_p  <= an_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (one_hot) begin
                        state <= STABLE;
                        count <= CW'(1);
                    end
                end
                STABLE: begin
                    if (!one_hot) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (changed) begin
                        count <= CW'(1);
                    end else if (capture) begin
                        state <= HELD;
                        count <= '0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                HELD: begin
                    if (changed) begin
                        state <= one_hot ? STABLE : IDLE;
                        count <= one_hot ? CW'(1) : '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Staging: a capture of the digit already seen simply overwrites it.
    // On completion seen restarts, keeping any capture of the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_digits <= '0;
            stg_err    <= '0;
            seen       <= '0;
        end else begin
            seen <= (complete ? '0 : seen) | (capture ? an_q : '0);
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (capture && an_q[k]) begin
                    stg_digits[4*k +: 4] <= bcd;
                    stg_err[k]           <= invalid;
                end
            end
        end
    end

    // Output frame: a new frame always wins; it only counts as an
    // overrun when the pending one is not taken on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_valid  <= 1'b0;
            frm_digits <= '0;
            frm_err    <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                frm_digits <= stg_digits;
                frm_err    <= stg_err;
                frm_valid  <= 1'b1;
                overrun    <= frm_valid && !frm_ready;
            end else if (frm_valid && frm_ready) begin
                frm_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (4 digits, 4 stable cycles).
// Ports exercised: all; frames are checked on each accepted handshake.
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = '0;
    logic [3:0]  an = '0;
    logic        frm_ready = 1'b1;
    logic        frm_valid;
    logic [15:0] frm_digits;
    logic [3:0]  frm_err;
    logic        overrun;

    localparam logic [6:0] DASH = 7'b0000001;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  e;
    } exp_t;

    exp_t exp_q[$];
    exp_t mx;
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   ovr_cnt = 0;

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg        (seg),
        .an         (an),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_digits (frm_digits),
        .frm_err    (frm_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expected frame per accepted handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) ovr_cnt++;
            if (frm_valid && frm_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %h expected none",
                             frm_digits);
                end else begin
                    mx = exp_q.pop_front();
                    chk("frame_digits", {16'h0, frm_digits}, {16'h0, mx.d});
                    chk("frame_err", {28'h0, frm_err}, {28'h0, mx.e});
                end
            end
        end
    end

    task automatic expect_frame(input logic [15:0] d, input logic [3:0] e);
        exp_t x;
        x.d = d;
        x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s,
                        input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        hold(4'b0001, p0, 6);
        hold(4'b0010, p1, 6);
        hold(4'b0100, p2, 6);
        hold(4'b1000, p3, 6);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        hold(4'b0000, 7'h00, 3);
        chk("rst_valid", {31'h0, frm_valid}, 0);
        chk("rst_digits", {16'h0, frm_digits}, 0);
        chk("rst_err", {28'h0, frm_err}, 0);
        chk("rst_overrun", {31'h0, overrun}, 0);
        rst_n = 1'b1;
        hold(4'b0000, 7'h00, 2);

        // basic scan
        expect_frame(16'h4321, 4'b0000);
        scan(SEG_1, SEG_2, SEG_3, SEG_4);
        hold(4'b0000, 7'h00, 3);
        drain("t1_drain");
        chk("t1_accepts", accepts, 1);
        chk("t1_overrun", ovr_cnt, 0);

        // short visit ignored, later revisit captured
        expect_frame(16'h4721, 4'b0000);
        hold(4'b0001, SEG_1, 6);
        hold(4'b0010, SEG_2, 6);
        hold(4'b0100, SEG_3, 3);
        hold(4'b0000, 7'h00, 4);
        hold(4'b0100, SEG_7, 6);
        hold(4'b1000, SEG_4, 6);
        hold(4'b0000, 7'h00, 3);
        drain("t2_drain");
        chk("t2_accepts", accepts, 2);

        // invalid pattern on digit 0
        expect_frame(16'h865F, 4'b0001);
        scan(DASH, SEG_5, SEG_6, SEG_8);
        hold(4'b0000, 7'h00, 3);
        drain("t3_drain");
        chk("t3_accepts", accepts, 3);

        // back-pressure across two frames
        frm_ready = 1'b0;
        scan(SEG_1, SEG_2, SEG_3, SEG_4);
        hold(4'b0000, 7'h00, 2);
        chk("t4_valid_first", {31'h0, frm_valid}, 1);
        chk("t4_digits_first", {16'h0, frm_digits}, 32'h4321);
        scan(SEG_5, SEG_6, SEG_7, SEG_8);
        hold(4'b0000, 7'h00, 4);
        chk("t4_valid_held", {31'h0, frm_valid}, 1);
        chk("t4_digits_new", {16'h0, frm_digits}, 32'h8765);
        chk("t4_err_new", {28'h0, frm_err}, 0);
        chk("t4_overrun", ovr_cnt, 1);
        chk("t4_no_accept", accepts, 3);
        expect_frame(16'h8765, 4'b0000);
        frm_ready = 1'b1;
        drain("t4_drain");
        hold(4'b0000, 7'h00, 2);
        chk("t4_accepts", accepts, 4);
        chk("t4_valid_clear", {31'h0, frm_valid}, 0);

        // blanking and multi-hot between digits
        expect_frame(16'h6789, 4'b0000);
        hold(4'b0001, SEG_9, 6);
        hold(4'b0011, DASH, 10);
        hold(4'b0010, SEG_8, 6);
        hold(4'b0000, 7'h00, 10);
        hold(4'b0100, SEG_7, 6);
        hold(4'b0011, SEG_1, 10);
        hold(4'b1000, SEG_6, 6);
        hold(4'b0000, 7'h00, 3);
        drain("t5_drain");
        chk("t5_accepts", accepts, 5);
        chk("t5_overrun", ovr_cnt, 1);

        // reset mid-frame discards partial progress
        hold(4'b0001, SEG_1, 6);
        hold(4'b0010, SEG_2, 6);
        rst_n = 1'b0;
        hold(4'b0000, 7'h00, 1);
        chk("t6_valid", {31'h0, frm_valid}, 0);
        chk("t6_digits", {16'h0, frm_digits}, 0);
        chk("t6_err", {28'h0, frm_err}, 0);
        chk("t6_overrun", {31'h0, overrun}, 0);
        rst_n = 1'b1;
        expect_frame(16'h0909, 4'b0000);
        hold(4'b0100, SEG_9, 6);
        hold(4'b1000, SEG_0, 6);
        hold(4'b0000, 7'h00, 8);
        chk("t6_no_early", accepts, 5);
        hold(4'b0001, SEG_9, 6);
        hold(4'b0010, SEG_0, 6);
        hold(4'b0000, 7'h00, 3);
        drain("t6_drain");
        chk("t6_accepts", accepts, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
